ber_checker: RTL and testbench
==============================

// Module: ber_checker
// PURPOSE
// - Per-branch bit-error-rate checker of the QPSK system. One instance for I, one for Q.
// - Compares slicer decisions against the transmitted PRBS bit stream.
// - Finds the channel/equalizer delay automatically, then accumulates error and total-bit counts.
// - Outputs drive the o_accum_err_* / o_accum_tot_* ports. The top register file snapshots these.
// PARAMETERS
// - NBT_COUNT_BITS_ERR  64   width of error and total-bit accumulators
// - PRBS_LEN            511  PRBS period; also depth of the tx delay line (max delay = PRBS_LEN-1)
// - NBT_DELAY           9    width of delay index, ceil(log2(PRBS_LEN))
// - SYNC_WINDOW         511  enabled bits evaluated per candidate delay during search
// - LOL_THRESHOLD       64   errors per SYNC_WINDOW that declare loss of lock (optional feature only)
// PORTS
// - clk          in   1                   DSP clock
// - i_reset      in   1                   asynchronous, active-high reset
// - i_enbl       in   1                   symbol strobe (rate-1 control); all state advances only when high
// - i_clear      in   1                   synchronous clear of accumulators; sync state is kept
// - i_bit_tx     in   1                   transmitted PRBS bit for this branch
// - i_bit_rx     in   1                   slicer decision bit (sign of slicer output) for this branch
// - o_accum_err  out  NBT_COUNT_BITS_ERR  errors counted since lock or clear
// - o_accum_tot  out  NBT_COUNT_BITS_ERR  bits counted since lock or clear
// - o_sync       out  1                   high while LOCKED
// - o_delay      out  NBT_DELAY           current candidate delay, or the locked delay
// BEHAVIOUR
// - Reset (async)
//   - Outputs: o_accum_err=0, o_accum_tot=0, o_sync=0, o_delay=0.
//   - Delay line, window counters and state are cleared; state = SEARCH.
// - Delay line
//   - PRBS_LEN-bit shift register. It shifts in i_bit_tx on every i_enbl, in every state.
//   - ref = line[o_delay]. Delay 0 is the tx bit registered on the previous enable.
//   - err_bit = i_bit_rx XOR ref.
// - Reset mid-operation: everything returns to reset values immediately. No partial state is kept.
// - FSM, state SEARCH
//   - Each enable: win_cnt++ and win_err += err_bit.
//   - On the enable with win_cnt==SYNC_WINDOW-1, the window is closed and evaluated.
//   - Lock criterion: final win_err==0, i.e. the count including this closing enable's err_bit. An error on the closing enable must fail the window.
//   - If the criterion holds: go to LOCKED and set o_sync=1 on the next cycle.
//   - Otherwise: o_delay++ (PRBS_LEN-1 wraps to 0), and win_cnt/win_err are reset.
//   - Accumulators hold 0 while searching.
// - FSM, state LOCKED
//   - Each enable: o_accum_tot += 1 and o_accum_err += err_bit.
//   - Update latency is 1 clk after the i_enbl cycle.
//   - Both counters saturate at all-ones. They never wrap.
//   - o_delay is frozen.
// - i_clear
//   - Zeroes both accumulators on the next edge.
//   - If i_clear and i_enbl are high in the same cycle, clear wins and that bit is not counted.
//   - In SEARCH, i_clear has no effect on the window counters.
// - i_enbl low: all registers except the delay line hold. The delay line also holds.
// - Worst-case acquisition: PRBS_LEN*SYNC_WINDOW enables.
// CONFIGURATION
// - BER_CHECKER_LOL_EN defined
//   - In LOCKED, a SYNC_WINDOW window of err_bit keeps running.
//   - If window errors >= LOL_THRESHOLD: return to SEARCH.
//     - Search restarts at o_delay+1 (with wrap).
//     - o_sync drops the cycle after the window closes.
//     - Accumulators keep their values and stop counting.
// - BER_CHECKER_LOL_EN undefined
//   - LOCKED is left only by i_reset.
//   - No loss-of-lock logic is synthesized.
// TESTING
// - Error-free lock: rx = tx delayed 37 enables
//   - o_sync rises after 38*511 enables; o_delay=37.
//   - After 1000 more enables: o_accum_tot=1000, o_accum_err=0.
// - Delay 0 and wrap: rx = tx delayed 0
//   - Lock at o_delay=0 after 511 enables.
//   - Separately, force 1 error per window at every delay: o_delay wraps 510->0 and o_sync stays 0.
// - Error counting: locked at delay 5; invert rx on every 10th bit for 1000 bits
//   - o_accum_err=100, o_accum_tot=1000.
// - Clear collision: i_clear and i_enbl high together in LOCKED
//   - Next cycle: both accumulators=0. The following enable gives tot=1.
// - Reset mid-search: assert i_reset asynchronously at o_delay=12
//   - All outputs are 0 without waiting for a clk edge.
//   - After release, search restarts from delay 0.
// - BER_CHECKER_LOL_EN: locked, then inject 64 errors in one window
//   - o_sync drops, o_delay increments, accumulators freeze.
//   - Without the macro, o_sync stays 1.

Source files
------------

// File: rtl/ber_checker_if.sv
// rtl/ber_checker_if.sv - bit stream and counter bundle between a BER checker and its user
interface ber_checker_if #(
   parameter int NBT_COUNT_BITS_ERR = 64,
   parameter int NBT_DELAY          = 9
);
   logic                          i_enbl;
   logic                          i_clear;
   logic                          i_bit_tx;
   logic                          i_bit_rx;
   logic [NBT_COUNT_BITS_ERR-1:0] o_accum_err;
   logic [NBT_COUNT_BITS_ERR-1:0] o_accum_tot;
   logic                          o_sync;
   logic [NBT_DELAY-1:0]          o_delay;

   modport master (
      output i_enbl, i_clear, i_bit_tx, i_bit_rx,
      input  o_accum_err, o_accum_tot, o_sync, o_delay
   );

   modport slave (
      input  i_enbl, i_clear, i_bit_tx, i_bit_rx,
      output o_accum_err, o_accum_tot, o_sync, o_delay
   );
endinterface

// File: rtl/ber_checker.sv
// rtl/ber_checker.sv - per-branch BER checker with automatic delay search; loss-of-lock via BER_CHECKER_LOL_EN
module ber_checker #(
   parameter int NBT_COUNT_BITS_ERR = 64,
   parameter int PRBS_LEN           = 511,
   parameter int NBT_DELAY          = 9,
   parameter int SYNC_WINDOW        = 511
`ifdef BER_CHECKER_LOL_EN
   ,
   parameter int LOL_THRESHOLD      = 64
`endif
) (
   input logic          clk,
   input logic          i_reset,
   ber_checker_if.slave bus
);
   localparam int NBT_WIN = $clog2(SYNC_WINDOW + 1);
   localparam logic [NBT_WIN-1:0]            WIN_LAST   = NBT_WIN'(SYNC_WINDOW - 1);
   localparam logic [NBT_DELAY-1:0]          DELAY_LAST = NBT_DELAY'(PRBS_LEN - 1);
   localparam logic [NBT_COUNT_BITS_ERR-1:0] CNT_MAX    = '1;

   typedef enum logic {SEARCH, LOCKED} state_t;

   state_t                        state;
   state_t                        state_nxt;
   logic [PRBS_LEN-1:0]           line;
   logic [NBT_DELAY-1:0]          delay;
   logic [NBT_WIN-1:0]            win_cnt;
   logic [NBT_WIN-1:0]            win_err;
   logic [NBT_WIN-1:0]            win_err_nxt;
   logic [NBT_COUNT_BITS_ERR-1:0] accum_err;
   logic [NBT_COUNT_BITS_ERR-1:0] accum_tot;
   logic                          err_bit;
   logic                          win_last;
   logic                          win_clean;
   logic                          win_run;
   logic                          lol_trip;
   logic                          delay_adv;

   // line[0] holds the tx bit of the previous enable, so delay d compares against tx d+1 enables ago
   assign err_bit     = bus.i_bit_rx ^ line[delay];
   assign win_last    = (win_cnt == WIN_LAST);
   assign win_err_nxt = win_err + NBT_WIN'(err_bit);
   // the closing bit is included, so an error on the last enable fails the window
   assign win_clean   = (win_err_nxt == '0);

`ifdef BER_CHECKER_LOL_EN
   assign win_run  = 1'b1;
   assign lol_trip = win_last && (32'(win_err_nxt) >= LOL_THRESHOLD);
`else
   assign win_run  = (state == SEARCH);
   assign lol_trip = 1'b0;
`endif

   // state register
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) state <= SEARCH;
      else         state <= state_nxt;
   end

   // next state and delay-advance decision, evaluated only on enables
   always_comb begin
      state_nxt = state;
      delay_adv = 1'b0;
      if (bus.i_enbl) begin
         case (state)
            SEARCH: begin
               if (win_last) begin
                  if (win_clean) state_nxt = LOCKED;
                  else           delay_adv = 1'b1;
               end
            end
            LOCKED: begin
               if (lol_trip) begin
                  state_nxt = SEARCH;
                  delay_adv = 1'b1;
               end
            end
            default: state_nxt = SEARCH;
         endcase
      end
   end

   // tx history shifts on every enable regardless of state
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset)         line <= '0;
      else if (bus.i_enbl) line <= {line[PRBS_LEN-2:0], bus.i_bit_tx};
   end

   // window bit/error counters; i_clear deliberately does not touch them
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         win_cnt <= '0;
         win_err <= '0;
      end else if (bus.i_enbl && win_run) begin
         if (win_last) begin
            win_cnt <= '0;
            win_err <= '0;
         end else begin
            win_cnt <= win_cnt + 1'b1;
            win_err <= win_err_nxt;
         end
      end
   end

   // candidate delay, wrapping from the last tap back to 0
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset)        delay <= '0;
      else if (delay_adv) delay <= (delay == DELAY_LAST) ? '0 : delay + 1'b1;
   end

   // saturating accumulators; clear beats a coincident enable, lock entry starts from zero
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         accum_err <= '0;
         accum_tot <= '0;
      end else if (bus.i_clear) begin
         accum_err <= '0;
         accum_tot <= '0;
      end else if (bus.i_enbl) begin
         if (state == LOCKED) begin
            if (accum_tot != CNT_MAX)            accum_tot <= accum_tot + 1'b1;
            if (err_bit && accum_err != CNT_MAX) accum_err <= accum_err + 1'b1;
         end else if (state_nxt == LOCKED) begin
            accum_err <= '0;
            accum_tot <= '0;
         end
      end
   end

   assign bus.o_accum_err = accum_err;
   assign bus.o_accum_tot = accum_tot;
   assign bus.o_sync      = (state == LOCKED);
   assign bus.o_delay     = delay;
endmodule

// File: tb/tb_ber_checker.sv
// tb/tb_ber_checker.sv - directed bench for ber_checker (full-size and small instances)
module tb_ber_checker;
   logic clk = 1'b0;
   logic i_reset;
   int   n_checks = 0;
   int   n_fail = 0;

   logic [8:0]   prbs_a;
   logic [510:0] hist_a;
   logic [3:0]   prbs_b;
   logic [14:0]  hist_b;

   always #5 clk = ~clk;

   ber_checker_if bus_a ();
   ber_checker_if #(.NBT_COUNT_BITS_ERR(4), .NBT_DELAY(4)) bus_b ();

   ber_checker dut_a (
      .clk     (clk),
      .i_reset (i_reset),
      .bus     (bus_a)
   );

   ber_checker #(
      .NBT_COUNT_BITS_ERR (4),
      .PRBS_LEN           (15),
      .NBT_DELAY          (4),
      .SYNC_WINDOW        (15)
   ) dut_b (
      .clk     (clk),
      .i_reset (i_reset),
      .bus     (bus_b)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic reset_model();
      prbs_a = 9'h1FF;
      hist_a = '0;
      prbs_b = 4'hF;
      hist_b = '0;
   endtask

   task automatic reset_all();
      i_reset = 1'b1;
      bus_a.i_enbl = 1'b0; bus_a.i_clear = 1'b0; bus_a.i_bit_tx = 1'b0; bus_a.i_bit_rx = 1'b0;
      bus_b.i_enbl = 1'b0; bus_b.i_clear = 1'b0; bus_b.i_bit_tx = 1'b0; bus_b.i_bit_rx = 1'b0;
      reset_model();
      repeat (2) @(posedge clk);
      #1;
      i_reset = 1'b0;
   endtask

   // rx = tx from dly+1 enables ago; bit k inverted when k%inv_mod==inv_mod-1 or k<inv_first
   task automatic run_a(input int n, input int dly, input int inv_mod, input int inv_first);
      logic tx, inv;
      for (int k = 0; k < n; k++) begin
         tx  = prbs_a[8];
         inv = ((inv_mod != 0) && (k % inv_mod == inv_mod - 1)) || (k < inv_first);
         bus_a.i_enbl   = 1'b1;
         bus_a.i_bit_tx = tx;
         bus_a.i_bit_rx = hist_a[dly] ^ inv;
         @(posedge clk);
         #1;
         hist_a = {hist_a[509:0], tx};
         prbs_a = {prbs_a[7:0], prbs_a[8] ^ prbs_a[4]};
      end
      bus_a.i_enbl = 1'b0;
   endtask

   task automatic run_b(input int n, input int dly, input int inv_mod);
      logic tx, inv;
      for (int k = 0; k < n; k++) begin
         tx  = prbs_b[3];
         inv = (inv_mod != 0) && (k % inv_mod == inv_mod - 1);
         bus_b.i_enbl   = 1'b1;
         bus_b.i_bit_tx = tx;
         bus_b.i_bit_rx = hist_b[dly] ^ inv;
         @(posedge clk);
         #1;
         hist_b = {hist_b[13:0], tx};
         prbs_b = {prbs_b[2:0], prbs_b[3] ^ prbs_b[2]};
      end
      bus_b.i_enbl = 1'b0;
   endtask

   initial begin
      reset_all();
      check("reset_sync",   bus_a.o_sync,      0);
      check("reset_delay",  bus_a.o_delay,     0);
      check("reset_err",    bus_a.o_accum_err, 0);
      check("reset_tot",    bus_a.o_accum_tot, 0);
      check("reset_sync_b", bus_b.o_sync,      0);

      // error-free lock at delay 37
      run_a(38 * 511 - 1, 37, 0, 0);
      check("d37_presync",  bus_a.o_sync,  0);
      check("d37_predelay", bus_a.o_delay, 37);
      run_a(1, 37, 0, 0);
      check("d37_sync",  bus_a.o_sync,      1);
      check("d37_delay", bus_a.o_delay,     37);
      check("d37_tot0",  bus_a.o_accum_tot, 0);
      run_a(1000, 37, 0, 0);
      check("d37_tot",   bus_a.o_accum_tot, 1000);
      check("d37_err",   bus_a.o_accum_err, 0);
      check("d37_hold",  bus_a.o_delay,     37);

      // clear colliding with an enable
      bus_a.i_clear = 1'b1;
      run_a(1, 37, 0, 0);
      bus_a.i_clear = 1'b0;
      check("clr_tot", bus_a.o_accum_tot, 0);
      check("clr_err", bus_a.o_accum_err, 0);
      run_a(1, 37, 0, 0);
      check("clr_tot1", bus_a.o_accum_tot, 1);
      check("clr_sync", bus_a.o_sync,      1);

      // delay 0 locks on the first window
      reset_all();
      run_a(510, 0, 0, 0);
      check("d0_presync", bus_a.o_sync, 0);
      run_a(1, 0, 0, 0);
      check("d0_sync",  bus_a.o_sync,  1);
      check("d0_delay", bus_a.o_delay, 0);

      // error counting at delay 5
      reset_all();
      run_a(6 * 511, 5, 0, 0);
      check("d5_sync",  bus_a.o_sync,  1);
      check("d5_delay", bus_a.o_delay, 5);
      run_a(1000, 5, 10, 0);
      check("d5_err", bus_a.o_accum_err, 100);
      check("d5_tot", bus_a.o_accum_tot, 1000);

      // 64 errors in the first locked window
      reset_all();
      run_a(6 * 511, 5, 0, 0);
      run_a(511, 5, 0, 64);
      check("lol_err", bus_a.o_accum_err, 64);
      check("lol_tot", bus_a.o_accum_tot, 511);
`ifdef BER_CHECKER_LOL_EN
      check("lol_sync",  bus_a.o_sync,  0);
      check("lol_delay", bus_a.o_delay, 6);
      run_a(10, 5, 0, 0);
      check("lol_frozen", bus_a.o_accum_tot, 511);
`else
      check("lol_sync",  bus_a.o_sync,  1);
      check("lol_delay", bus_a.o_delay, 5);
      run_a(10, 5, 0, 0);
      check("lol_count", bus_a.o_accum_tot, 521);
`endif

      // asynchronous reset in the middle of the delay-12 window
      reset_all();
      run_a(12 * 511 + 100, 37, 0, 0);
      check("mid_delay12", bus_a.o_delay, 12);
      #2;
      i_reset = 1'b1;
      #1;
      check("async_delay", bus_a.o_delay,     0);
      check("async_sync",  bus_a.o_sync,      0);
      check("async_err",   bus_a.o_accum_err, 0);
      check("async_tot",   bus_a.o_accum_tot, 0);
      @(posedge clk);
      #1;
      i_reset = 1'b0;
      reset_model();
      run_a(511, 37, 0, 0);
      check("restart_delay", bus_a.o_delay, 1);
      check("restart_sync",  bus_a.o_sync,  0);

      // small instance: one error on each window's closing bit forces a full wrap
      reset_all();
      run_b(14 * 15, 3, 15);
      check("wrap_delay14", bus_b.o_delay, 14);
      check("wrap_sync14",  bus_b.o_sync,  0);
      run_b(15, 3, 15);
      check("wrap_delay0", bus_b.o_delay, 0);
      check("wrap_sync0",  bus_b.o_sync,  0);
      run_b(3 * 15, 3, 0);
      check("b_delay3", bus_b.o_delay, 3);
      check("b_presync", bus_b.o_sync, 0);
      run_b(15, 3, 0);
      check("b_sync",  bus_b.o_sync,  1);
      check("b_delay", bus_b.o_delay, 3);
      // every bit wrong: 4-bit counters saturate at 15
      run_b(20, 3, 1);
      check("sat_err", bus_b.o_accum_err, 15);
      check("sat_tot", bus_b.o_accum_tot, 15);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
